// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the MMIO UART transmitter.
// Serialiser state enum, register offsets and STATUS bit positions.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } txState_t;

    localparam int TXDATA_OFS = 0;
    localparam int STATUS_OFS = 4;

    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_BUSY      = 2;
    localparam int STAT_OVF       = 3;
    localparam int STAT_COUNT_LSB = 8;

endpackage

// File: rtl/tx_fifo.sv
// tx_fifo: synchronous FIFO feeding the UART serialiser.
// Ports: clock, reset (sync, active-high), push/wrData, pop/rdData,
//        full, empty, count (registered occupancy, 0..Depth).
module tx_fifo #(
    parameter int Width = 8,
    parameter int Depth = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [Width-1:0]       wrData,
    input  logic                   pop,
    output logic [Width-1:0]       rdData,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(Depth):0] count
);

    localparam int AW = $clog2(Depth);
    localparam int CW = AW + 1;

    logic [Width-1:0] mem [Depth];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             pushOk;
    logic             popOk;

    // Full/empty come from the registered count, so a push against a
    // full FIFO is refused even if a pop happens on the same edge.
    assign full   = (count == CW'(Depth));
    assign empty  = (count == '0);
    assign pushOk = push && !full;
    assign popOk  = pop && !empty;
    assign rdData = mem[rdPtr];

    always_ff @(posedge clock) begin
        if (pushOk) begin
            mem[wrPtr] <= wrData;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (pushOk) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (popOk) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({pushOk, popOk})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter on the data-memory port.
// Ports: clock, reset (sync, active-high), RAMAddr, DataIn, RAMWriteControl
//        (store strobe), UartSel (address hit), StatusOut (STATUS word),
//        TxOut (serial line, idle high).
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int                     dataW       = 32,
    parameter int                     RAMAddrSize = 16,
    parameter logic [RAMAddrSize-1:0] BaseAddr    = RAMAddrSize'(16'hFF00),
    parameter int                     FifoDepth   = 8,
    parameter int                     ClksPerBit  = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [RAMAddrSize-1:0] RAMAddr,
    input  logic [dataW-1:0]       DataIn,
    input  logic                   RAMWriteControl,
    output logic                   UartSel,
    output logic [dataW-1:0]       StatusOut,
    output logic                   TxOut
);

    localparam int CW = $clog2(FifoDepth) + 1;
    localparam int BW = $clog2(ClksPerBit);

    localparam logic [RAMAddrSize-1:0] TxAddr =
        BaseAddr + RAMAddrSize'(TXDATA_OFS);
    localparam logic [RAMAddrSize-1:0] StatAddr =
        BaseAddr + RAMAddrSize'(STATUS_OFS);

    logic          hitTx;
    logic          hitStat;
    logic          fifoPush;
    logic          fifoPop;
    logic [7:0]    fifoHead;
    logic          fifoFull;
    logic          fifoEmpty;
    logic [CW-1:0] fifoCount;
    logic          ovf;
    logic [dataW-1:0] statusWord;

    txState_t      state;
    txState_t      stateNext;
    logic [BW-1:0] baudCnt;
    logic [BW-1:0] baudNext;
    logic [2:0]    bitIdx;
    logic [2:0]    bitNext;
    logic [7:0]    shiftReg;
    logic [7:0]    shiftNext;
    logic          txReg;
    logic          txNext;
    logic          lastBaud;

    logic unusedBits;
    assign unusedBits = ^{DataIn[dataW-1:8], RAMAddr[1:0]};

    // Word-granular decode: the two byte-lane bits are ignored.
    assign hitTx   = RAMAddr[RAMAddrSize-1:2] == TxAddr[RAMAddrSize-1:2];
    assign hitStat = RAMAddr[RAMAddrSize-1:2] == StatAddr[RAMAddrSize-1:2];
    assign UartSel = hitTx || hitStat;

    assign fifoPush = RAMWriteControl && hitTx && !reset;

    tx_fifo #(
        .Width (8),
        .Depth (FifoDepth)
    ) uFifo (
        .clock  (clock),
        .reset  (reset),
        .push   (fifoPush),
        .wrData (DataIn[7:0]),
        .pop    (fifoPop),
        .rdData (fifoHead),
        .full   (fifoFull),
        .empty  (fifoEmpty),
        .count  (fifoCount)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (RAMWriteControl && hitStat) begin
            ovf <= 1'b0;
        end else if (RAMWriteControl && hitTx && fifoFull) begin
            ovf <= 1'b1;
        end
    end

    always_comb begin
        statusWord = '0;
        statusWord[STAT_FULL]  = fifoFull;
        statusWord[STAT_EMPTY] = fifoEmpty;
        statusWord[STAT_BUSY]  = (state != IDLE);
        statusWord[STAT_OVF]   = ovf;
        statusWord[STAT_COUNT_LSB +: CW] = fifoCount;
    end

    assign StatusOut = UartSel ? statusWord : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            baudCnt  <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
            txReg    <= 1'b1;
        end else begin
            state    <= stateNext;
            baudCnt  <= baudNext;
            bitIdx   <= bitNext;
            shiftReg <= shiftNext;
            txReg    <= txNext;
        end
    end

    assign lastBaud = (baudCnt == BW'(ClksPerBit - 1));

    always_comb begin
        stateNext = state;
        baudNext  = baudCnt;
        bitNext   = bitIdx;
        shiftNext = shiftReg;
        fifoPop   = 1'b0;
        txNext    = 1'b1;

        unique case (state)
            IDLE: begin
                if (!fifoEmpty) begin
                    fifoPop   = 1'b1;
                    shiftNext = fifoHead;
                    stateNext = START;
                    baudNext  = '0;
                end
            end
            START: begin
                if (lastBaud) begin
                    stateNext = DATA;
                    bitNext   = '0;
                    baudNext  = '0;
                end else begin
                    baudNext = baudCnt + 1'b1;
                end
            end
            DATA: begin
                if (lastBaud) begin
                    baudNext  = '0;
                    shiftNext = shiftReg >> 1;
                    if (bitIdx == 3'd7) begin
                        stateNext = STOP;
                    end else begin
                        bitNext = bitIdx + 1'b1;
                    end
                end else begin
                    baudNext = baudCnt + 1'b1;
                end
            end
            STOP: begin
                if (lastBaud) begin
                    baudNext = '0;
                    // Chain straight into the next start bit when more
                    // data is queued, keeping frames contiguous.
                    if (!fifoEmpty) begin
                        fifoPop   = 1'b1;
                        shiftNext = fifoHead;
                        stateNext = START;
                    end else begin
                        stateNext = IDLE;
                    end
                end else begin
                    baudNext = baudCnt + 1'b1;
                end
            end
        endcase

        // Line level is registered alongside the state it belongs to.
        unique case (stateNext)
            IDLE:    txNext = 1'b1;
            START:   txNext = 1'b0;
            DATA:    txNext = shiftNext[0];
            STOP:    txNext = 1'b1;
        endcase
    end

    assign TxOut = txReg;

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
Memory-mapped UART transmitter on the processor's data-memory port, downstream of the core's RAM address/data/write-enable outputs. Stores to the TXDATA address push the low byte into a TX FIFO. A baud-rate FSM serialises queued bytes as 8N1 frames on a single output pin. A combinational STATUS read path lets the top level mux UART status into the load-data path alongside RAM output.

Parameters:
dataW, 32, data bus width; must be ≥ 8.
RAMAddrSize, 16, width of the data-memory address bus.
BaseAddr, 16'hFF00, byte address of TXDATA; STATUS is at BaseAddr+4; must be word-aligned.
FifoDepth, 8, TX FIFO entries; power of two, ≥ 2.
ClksPerBit, 16, clock cycles per serial bit; ≥ 2.

Ports:
clock  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high; sampled on the rising edge of clock.
RAMAddr  input  RAMAddrSize  data-memory byte address from the core.
DataIn  input  dataW  store data; bits [7:0] used for TXDATA.
RAMWriteControl  input  1  store strobe; one store per cycle while high.
UartSel  output  1  combinational; high when RAMAddr hits TXDATA or STATUS.
StatusOut  output  dataW  combinational STATUS word, valid when UartSel is high; zero otherwise.
TxOut  output  1  serial line; idle high.

Behaviour:
- Address decode compares RAMAddr[RAMAddrSize-1:2] only; bits [1:0] are ignored.
- TXDATA store: on a clock edge with RAMWriteControl=1 and a TXDATA hit, DataIn[7:0] is pushed if the FIFO is not full. "Full" is evaluated on registered count before any same-cycle pop.
- Store while full: the byte is dropped, the FIFO is unchanged, and sticky OVF is set. This holds even if a pop happens in the same cycle.
- STATUS store: any write to STATUS clears OVF. Other bits are read-only.
- STATUS layout:
  - bit0 FULL
  - bit1 EMPTY
  - bit2 BUSY (FSM not IDLE)
  - bit3 OVF
  - bits[8+CW-1:8] count, where CW = $clog2(FifoDepth)+1
  - all other bits zero
- Reads are zero-latency and combinational from registered state, so a same-cycle write is not reflected until the next cycle.
- FSM states: IDLE, START, DATA, STOP. Baud counter runs 0..ClksPerBit-1; bit index runs 0..7.
  - IDLE: TxOut=1. If the FIFO is non-empty, pop the head into the shift register, go to START, and clear the baud counter.
  - START: TxOut=0 for ClksPerBit cycles, then DATA with bit index 0.
  - DATA: TxOut = shift[0], LSB first. Each bit lasts ClksPerBit cycles, then shift right. After bit 7 go to STOP.
  - STOP: TxOut=1 for ClksPerBit cycles. On the last STOP cycle, if the FIFO is non-empty, pop and go directly to START (no gap); otherwise go to IDLE.
- Latency: a store accepted at edge N with an empty FIFO and FSM in IDLE pops at edge N+1, and TxOut falls after edge N+1.
- Frame length: exactly 10*ClksPerBit cycles. Back-to-back frames are contiguous.
- Simultaneous push and pop while not full: both take effect and count is unchanged.
- FIFO pointers wrap modulo FifoDepth. Count saturates conceptually at FifoDepth and is never exceeded.
- Reset, including mid-frame: on the reset edge, FSM goes to IDLE, TxOut=1, FIFO is emptied (count 0, pointers 0), OVF=0, baud counter and bit index are 0.
- Stores during reset are ignored. UartSel and StatusOut stay combinational during reset.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE/START/DATA/STOP)
  - register offsets: TXDATA_OFS=0, STATUS_OFS=4
  - STATUS bit index constants (FULL, EMPTY, BUSY, OVF, COUNT_LSB=8)
- Sub-module tx_fifo: synchronous FIFO with push/pop/full/empty/count, parameterised on width 8 and FifoDepth, same clock and reset.
- The top of uart_tx_mmio contains the decode, the STATUS mux and the serialiser FSM.

Test Plan:
- Reset state, ClksPerBit=4 (all remaining scenarios also use ClksPerBit=4): assert reset for 2 cycles → TxOut=1 and STATUS reads 0x0000_0002 (EMPTY only).
- Single byte: store 0x41 to 0xFF00 at edge N → TxOut=0 for cycles N+1..N+4, then bits 1,0,0,0,0,0,1,0 at 4 cycles each, then 1 for 4 cycles. BUSY drops after 40 cycles, then STATUS reads 0x0000_0002.
- Back-to-back: store 0x55 then 0xAA on consecutive cycles → two contiguous 40-cycle frames with no idle cycle between the stop bit and the second start bit. Count reads 1 after the first pop.
- Overflow: hold FSM busy, fill 8 entries plus 1 more store (0xEE) → count=8, FULL=1, OVF=1, and 0xEE is never transmitted. A store to 0xFF04 then reads OVF=0 with FULL still 1.
- Address alias/miss: store 0x33 to 0xFF02 → accepted as TXDATA. Store to 0xFF08 → UartSel=0, no push, StatusOut=0.
- Reset mid-frame: assert reset during DATA bit 3 with 3 bytes queued → TxOut=1 on the next edge, count=0, no further frames after reset release.
